normaliz_seq: RTL



---
 rtl/normaliz_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/normaliz_seq.sv
// rtl/normaliz_seq.sv - multi-cycle mantissa normaliser with valid/ready handshake
// Shifts the working mantissa until the hidden bit is set, then classifies and registers the result.
module normaliz_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W+1:0]  sum_mants,
  input  logic [EXP_W-1:0]   exp_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  mant_norm,
  output logic [EXP_W-1:0]   exp_out,
  output logic [EXP_W:0]     val2,
  output logic               zero,
  output logic               overflow,
  output logic               underflow
);

  typedef enum logic [1:0] {IDLE, NORM, FIN, DONE} state_t;

  localparam logic [EXP_W-1:0] STEP_E   = EXP_W'(STEP);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, EXP_ONES};

  state_t               state, state_next;
  logic                 sign_q, sign_d;
  logic [MANT_W:0]      mant_q, mant_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [EXP_W-1:0]     cnt_q, cnt_d;
  logic                 rshift_q, rshift_d;
  logic                 zcls_q, zcls_d;

  logic [MANT_W-1:0]    mant_norm_d;
  logic [EXP_W-1:0]     exp_out_d;
  logic [EXP_W:0]       val2_d;
  logic                 zero_d, overflow_d, underflow_d;

  logic [EXP_W:0]       exp_inc;
  logic [EXP_W:0]       exp_dec;
  logic [MANT_W-1:0]    mant_keep;
  logic [MANT_W-1:0]    mant_flush;

  assign exp_inc    = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
  assign exp_dec    = {1'b0, exp_q} - {1'b0, cnt_q};
  assign mant_keep  = {sign_q, mant_q[MANT_W-2:0]};
  assign mant_flush = {sign_q, {(MANT_W-1){1'b0}}};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_next  = state;
    sign_d      = sign_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    rshift_d    = rshift_q;
    zcls_d      = zcls_q;
    mant_norm_d = mant_norm;
    exp_out_d   = exp_out;
    val2_d      = val2;
    zero_d      = zero;
    overflow_d  = overflow;
    underflow_d = underflow;

    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_d     = sum_mants[MANT_W+1];
          mant_d     = sum_mants[MANT_W:0];
          exp_d      = exp_in;
          cnt_d      = '0;
          rshift_d   = 1'b0;
          zcls_d     = 1'b0;
          state_next = NORM;
        end
      end
      NORM: begin
        if (mant_q[MANT_W]) begin
          mant_d     = mant_q >> 1;
          cnt_d      = {{(EXP_W-1){1'b0}}, 1'b1};
          rshift_d   = 1'b1;
          state_next = FIN;
        end else if (mant_q[MANT_W-1]) begin
          state_next = FIN;
        end else if (mant_q == '0) begin
          zcls_d     = 1'b1;
          state_next = FIN;
        end else if (mant_q[MANT_W-1 -: STEP] == '0) begin
          // All STEP top bits clear, so a full-step shift cannot pass the hidden bit.
          mant_d = mant_q << STEP;
          cnt_d  = cnt_q + STEP_E;
        end else begin
          mant_d = mant_q << 1;
          cnt_d  = cnt_q + {{(EXP_W-1){1'b0}}, 1'b1};
        end
      end
      FIN: begin
        zero_d      = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        mant_norm_d = mant_keep;
        if (zcls_q) begin
          zero_d      = 1'b1;
          exp_out_d   = '0;
          mant_norm_d = mant_flush;
          val2_d      = {1'b0, EXP_ONES};
        end else if (rshift_q) begin
          val2_d = {1'b0, cnt_q};
          if (exp_inc >= EXP_MAX) begin
            overflow_d  = 1'b1;
            exp_out_d   = EXP_ONES;
            mant_norm_d = mant_flush;
          end else begin
            exp_out_d = exp_inc[EXP_W-1:0];
          end
        end else if (cnt_q != '0) begin
          val2_d = {1'b1, cnt_q};
          // Borrow out or an exact zero both mean the exponent fell below 1.
          if (exp_dec[EXP_W] || exp_dec == '0) begin
            underflow_d = 1'b1;
            exp_out_d   = '0;
            mant_norm_d = mant_flush;
          end else begin
            exp_out_d = exp_dec[EXP_W-1:0];
          end
        end else begin
          val2_d    = '0;
          exp_out_d = exp_q;
        end
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mant_q    <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      rshift_q  <= 1'b0;
      zcls_q    <= 1'b0;
      mant_norm <= '0;
      exp_out   <= '0;
      val2      <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      sign_q    <= sign_d;
      mant_q    <= mant_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      rshift_q  <= rshift_d;
      zcls_q    <= zcls_d;
      mant_norm <= mant_norm_d;
      exp_out   <= exp_out_d;
      val2      <= val2_d;
      zero      <= zero_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

endmodule
